// File: rtl/ysyx_23060203_ifu_if.sv
// Fetch unit bus bundle: imem request/response, decode hand-off,
// commit feedback and status.
interface ysyx_23060203_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  imem_resp_err,
    output out_valid,
    input  out_ready,
    output inst,
    output pc,
    input  commit_valid,
    input  commit_pc,
    output fetch_err,
    output fetch_cnt
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output imem_resp_err,
    input  out_valid,
    output out_ready,
    input  inst,
    input  pc,
    output commit_valid,
    output commit_pc,
    input  fetch_err,
    input  fetch_cnt
  );
endinterface

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit for a multi-cycle core: one fetch in
// flight, next fetch starts once the back end commits the next pc.
module ysyx_23060203_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_23060203_ifu_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_COMMIT,
    S_ERR
  } state_t;

  state_t      r_state;
  logic        r_req_valid;
  logic        r_out_valid;
  logic        r_err;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_cnt;
  logic        w_misaligned;

  assign w_misaligned = |bus.commit_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_pc        <= RESET_PC;
      r_inst      <= 32'd0;
      r_cnt       <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (bus.imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            if (bus.imem_resp_err) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_inst      <= bus.imem_resp_data;
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_cnt       <= r_cnt + 32'd1;
            r_state     <= S_COMMIT;
            r_out_valid <= 1'b0;
          end
        end
        S_COMMIT: begin
          if (bus.commit_valid) begin
            r_pc <= bus.commit_pc;
            if (w_misaligned) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.out_valid      = r_out_valid;
  assign bus.inst           = r_inst;
  assign bus.pc             = r_pc;
  assign bus.fetch_err      = r_err;
  assign bus.fetch_cnt      = r_cnt;

endmodule
